// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the encipher and decipher blocks.
// Contents: Nk/Nr constants, the controller state enum, the forward and
// inverse S-box tables, and the byte/state helper functions.
// This package has no ports.
package aes_pkg;

    localparam int NK = 4;
    localparam int NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_ADD  = 2'd2
    } state_t;

    // Entry 0 is the most significant byte of each literal.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse of xtime in GF(2^8); walks the round constants backwards.
    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        return b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Byte n of the state sits at bits [127-8n -: 8]; row r, column c is n = r + 4c.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a, x2, x4, x8;
        logic [7:0]   m9 [4];
        logic [7:0]   mb [4];
        logic [7:0]   md [4];
        logic [7:0]   me [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a  = s[127-8*(4*c+r) -: 8];
                x2 = xtime(a);
                x4 = xtime(x2);
                x8 = xtime(x4);
                m9[r] = x8 ^ a;
                mb[r] = x8 ^ x2 ^ a;
                md[r] = x8 ^ x4 ^ a;
                me[r] = x8 ^ x4 ^ x2;
            end
            o[127-32*c -: 32] = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                                 m9[0] ^ me[1] ^ mb[2] ^ md[3],
                                 md[0] ^ m9[1] ^ me[2] ^ mb[3],
                                 mb[0] ^ md[1] ^ m9[2] ^ me[3]};
        end
        return o;
    endfunction

    // Recovers round key i-1 from round key i; rc is the constant used to make key i.
    function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]   ^ k[63:32];
        w2 = k[63:32]  ^ k[95:64];
        w1 = k[95:64]  ^ k[127:96];
        w0 = k[127:96] ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_if.sv
// Handshake and observation bundle for the AES-128 decipher block.
// master: source side (drives key, block, valid; observes the rest).
// slave : decipher side (s_aes_ready, m_aes_block, m_aes_valid, round, round_key).
interface aes_if;
    import aes_pkg::*;

    logic [127:0] s_aes_key;
    logic [127:0] s_aes_block;
    logic         s_aes_valid;
    logic         s_aes_ready;
    logic [127:0] m_aes_block;
    logic         m_aes_valid;
    logic [3:0]   round;
    logic [127:0] round_key;

    modport master (
        output s_aes_key, s_aes_block, s_aes_valid,
        input  s_aes_ready, m_aes_block, m_aes_valid, round, round_key
    );

    modport slave (
        input  s_aes_key, s_aes_block, s_aes_valid,
        output s_aes_ready, m_aes_block, m_aes_valid, round, round_key
    );
endinterface

// File: rtl/aes_inv_sbox_word.sv
// 32-bit combinational inverse S-box: four parallel byte lookups.
// Ports: din (32-bit word in), dout (InvSubBytes of din).
module aes_inv_sbox_word
    import aes_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);
    assign dout = {INV_SBOX[din[31:24]], INV_SBOX[din[23:16]],
                   INV_SBOX[din[15:8]],  INV_SBOX[din[7:0]]};
endmodule

// File: rtl/aes_dec.sv
// Iterative AES-128 inverse cipher with on-the-fly inverse key expansion.
// Ports: clk, rst (async, active high), bus (aes_if.slave):
//   s_aes_key/s_aes_block/s_aes_valid/s_aes_ready  input handshake
//   m_aes_block/m_aes_valid                        result, one-cycle valid pulse
//   round/round_key                                current round index and key
// FAST_MODE=1 substitutes all four words per cycle; 0 does one word per cycle.
module aes_dec
    import aes_pkg::*;
#(
    parameter bit FAST_MODE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    aes_if.slave bus
);
    state_t       state, state_nxt;
    logic [127:0] blk, rkey, isr_blk, sub_res;
    logic [3:0]   rnd;
    logic [7:0]   rcon;
    logic [1:0]   wcnt;
    logic         valid_q, ready, accept, sub_first, sub_last;

    assign accept    = bus.s_aes_valid && ready;
    assign sub_first = FAST_MODE || (wcnt == 2'd0);
    assign sub_last  = FAST_MODE || (wcnt == 2'd3);
    assign isr_blk   = inv_shift_rows(blk);

    if (FAST_MODE) begin : g_fast
        for (genvar i = 0; i < 4; i++) begin : g_word
            aes_inv_sbox_word u_isb (
                .din  (isr_blk[127-32*i -: 32]),
                .dout (sub_res[127-32*i -: 32])
            );
        end
    end else begin : g_slow
        // First pass applies the row shift to the whole state and substitutes
        // word 0; the later passes substitute the remaining words in place.
        logic [127:0] sub_src;
        logic [31:0]  word_in, word_out;

        assign sub_src = (wcnt == 2'd0) ? isr_blk : blk;

        aes_inv_sbox_word u_isb (
            .din  (word_in),
            .dout (word_out)
        );

        always_comb begin
            word_in = sub_src[127:96];
            case (wcnt)
                2'd1:    word_in = sub_src[95:64];
                2'd2:    word_in = sub_src[63:32];
                2'd3:    word_in = sub_src[31:0];
                default: word_in = sub_src[127:96];
            endcase
        end

        always_comb begin
            sub_res = sub_src;
            case (wcnt)
                2'd1:    sub_res[95:64]  = word_out;
                2'd2:    sub_res[63:32]  = word_out;
                2'd3:    sub_res[31:0]   = word_out;
                default: sub_res[127:96] = word_out;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_SUB;
            ST_SUB:  if (sub_last) state_nxt = ST_ADD;
            ST_ADD:  state_nxt = (rnd == 4'd0) ? ST_IDLE : ST_SUB;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = (state == ST_IDLE) && !rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk     <= '0;
            rkey    <= '0;
            rnd     <= '0;
            rcon    <= '0;
            wcnt    <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        blk  <= bus.s_aes_block ^ bus.s_aes_key;
                        rkey <= bus.s_aes_key;
                        rnd  <= 4'(NR);
                        rcon <= 8'h36;
                        wcnt <= '0;
                    end
                end
                ST_SUB: begin
                    blk  <= sub_res;
                    wcnt <= sub_last ? 2'd0 : wcnt + 2'd1;
                    if (sub_first) begin
                        rkey <= inv_key_step(rkey, rcon);
                        rcon <= inv_xtime(rcon);
                        rnd  <= rnd - 4'd1;
                    end
                end
                ST_ADD: begin
                    if (rnd != 4'd0) begin
                        blk <= inv_mix_columns(blk ^ rkey);
                    end else begin
                        blk     <= blk ^ rkey;
                        valid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.s_aes_ready = ready;
    assign bus.m_aes_block = blk;
    assign bus.m_aes_valid = valid_q;
    assign bus.round       = rnd;
    assign bus.round_key   = rkey;

endmodule

// File: tb/tb_aes_dec.sv
module tb_aes_dec;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_if bus_f ();
    aes_if bus_s ();

    aes_dec #(.FAST_MODE(1'b1)) u_fast (.clk(clk), .rst(rst), .bus(bus_f.slave));
    aes_dec #(.FAST_MODE(1'b0)) u_slow (.clk(clk), .rst(rst), .bus(bus_s.slave));

    localparam logic [127:0] KC1  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] CC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PC1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K0C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KB   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] CB   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PB   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K0B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb [256];
    logic [7:0] rtab [10] = '{8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic drive(input bit fast, input logic [127:0] k, input logic [127:0] b, input logic v);
        if (fast) begin
            bus_f.s_aes_key = k; bus_f.s_aes_block = b; bus_f.s_aes_valid = v;
        end else begin
            bus_s.s_aes_key = k; bus_s.s_aes_block = b; bus_s.s_aes_valid = v;
        end
    endtask

    function automatic logic g_ready(input bit fast);
        return fast ? bus_f.s_aes_ready : bus_s.s_aes_ready;
    endfunction
    function automatic logic g_valid(input bit fast);
        return fast ? bus_f.m_aes_valid : bus_s.m_aes_valid;
    endfunction
    function automatic logic [127:0] g_block(input bit fast);
        return fast ? bus_f.m_aes_block : bus_s.m_aes_block;
    endfunction
    function automatic logic [3:0] g_round(input bit fast);
        return fast ? bus_f.round : bus_s.round;
    endfunction
    function automatic logic [127:0] g_rkey(input bit fast);
        return fast ? bus_f.round_key : bus_s.round_key;
    endfunction

    // ---------------- reference forward cipher ----------------
    function automatic logic [7:0] txtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = txtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] tsub_word(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [127:0] enc_round(input logic [127:0] s, input bit mix);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = sb[s[127-8*(4*((c+r)%4)+r) -: 8]];
        if (mix) begin
            for (int c = 0; c < 4; c++) begin
                a0 = o[127-32*c -: 8]; a1 = o[119-32*c -: 8];
                a2 = o[111-32*c -: 8]; a3 = o[103-32*c -: 8];
                o[127-32*c -: 32] = {txtime(a0) ^ txtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ txtime(a1) ^ txtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ txtime(a2) ^ txtime(a3) ^ a3,
                                     txtime(a0) ^ a0 ^ a1 ^ a2 ^ txtime(a3)};
            end
        end
        return o;
    endfunction

    task automatic encrypt(input logic [127:0] key, input logic [127:0] pt,
                           output logic [127:0] ct, output logic [127:0] rk);
        logic [127:0] s;
        logic [31:0]  w0, w1, w2, w3;
        logic [7:0]   rc;
        rk = key;
        s  = pt ^ key;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            s  = enc_round(s, r < 10);
            w0 = rk[127:96] ^ tsub_word({rk[23:0], rk[31:24]}) ^ {rc, 24'h0};
            w1 = rk[95:64] ^ w0;
            w2 = rk[63:32] ^ w1;
            w3 = rk[31:0]  ^ w2;
            rk = {w0, w1, w2, w3};
            rc = txtime(rc);
            s  = s ^ rk;
        end
        ct = s;
    endtask

    // ---------------- directed step helpers ----------------
    task automatic run_vec(input bit fast, input logic [127:0] k, input logic [127:0] ct,
                           input logic [127:0] pt, input logic [127:0] k0, input int lat,
                           input string tag);
        int n;
        @(negedge clk);
        chk({tag, "_ready"}, 128'(g_ready(fast)), 128'(1));
        drive(fast, k, ct, 1'b1);
        @(negedge clk);
        drive(fast, '0, '0, 1'b0);
        n = 0;
        while (!g_valid(fast) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 128'(n), 128'(lat));
        chk({tag, "_pt"}, g_block(fast), pt);
        chk({tag, "_rkey"}, g_rkey(fast), k0);
        chk({tag, "_round"}, 128'(g_round(fast)), 128'(0));
        @(negedge clk);
        chk({tag, "_pulse"}, 128'(g_valid(fast)), 128'(0));
        chk({tag, "_hold"}, g_block(fast), pt);
    endtask

    task automatic b2b(input bit fast, input int lat, input string tag);
        int n;
        @(negedge clk);
        drive(fast, KC1, CC1, 1'b1);
        @(negedge clk);
        drive(fast, KB, CB, 1'b1);
        chk({tag, "_busy_ready"}, 128'(g_ready(fast)), 128'(0));
        n = 0;
        while (!g_valid(fast) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat1"}, 128'(n), 128'(lat));
        chk({tag, "_pt1"}, g_block(fast), PC1);
        chk({tag, "_ready_in_valid"}, 128'(g_ready(fast)), 128'(1));
        @(negedge clk);
        drive(fast, '0, '0, 1'b0);
        chk({tag, "_no_gap"}, 128'(g_ready(fast)), 128'(0));
        chk({tag, "_round2"}, 128'(g_round(fast)), 128'(10));
        n = 0;
        while (!g_valid(fast) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat2"}, 128'(n), 128'(lat));
        chk({tag, "_pt2"}, g_block(fast), PB);
    endtask

    initial begin
        logic [127:0] key, pt, ct, rk, gf, gs;
        logic [7:0]   bb;
        bit           df, ds;
        int           n, pulses, er;

        sb[0] = 8'h63;
        for (int x = 1; x < 256; x++) begin
            bb = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) bb = 8'(y);
            sb[x] = bb ^ {bb[6:0], bb[7]} ^ {bb[5:0], bb[7:6]} ^ {bb[4:0], bb[7:5]}
                       ^ {bb[3:0], bb[7:4]} ^ 8'h63;
        end

        rst = 1'b1;
        drive(1'b1, '0, '0, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        #1;
        chk("rst_ready_f", 128'(bus_f.s_aes_ready), 128'(0));
        chk("rst_ready_s", 128'(bus_s.s_aes_ready), 128'(0));
        chk("rst_block_f", bus_f.m_aes_block, '0);
        chk("rst_valid_f", 128'(bus_f.m_aes_valid), 128'(0));
        chk("rst_round_f", 128'(bus_f.round), 128'(0));
        chk("rst_rkey_s", bus_s.round_key, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_ready_f", 128'(bus_f.s_aes_ready), 128'(1));
        chk("rel_ready_s", 128'(bus_s.s_aes_ready), 128'(1));

        run_vec(1'b1, KC1, CC1, PC1, K0C1, 20, "c1_fast");
        run_vec(1'b0, KC1, CC1, PC1, K0C1, 50, "c1_slow");

        // App. B on the fast core with a per-cycle round and rcon trace.
        @(negedge clk);
        drive(1'b1, KB, CB, 1'b1);
        @(negedge clk);
        drive(1'b1, '0, '0, 1'b0);
        for (int k = 0; k <= 20; k++) begin
            er = 10 - (k + 1) / 2;
            chk("b_round_trace", 128'(bus_f.round), 128'(er));
            if (er >= 1) chk("b_rcon_trace", 128'(u_fast.rcon), 128'(rtab[10-er]));
            chk("b_valid_trace", 128'(bus_f.m_aes_valid), 128'(k == 20));
            if (k < 20) @(negedge clk);
        end
        chk("b_fast_pt", bus_f.m_aes_block, PB);
        chk("b_fast_rkey", bus_f.round_key, K0B);

        run_vec(1'b0, KB, CB, PB, K0B, 50, "b_slow");

        b2b(1'b1, 20, "b2b_fast");
        b2b(1'b0, 50, "b2b_slow");

        // Reset in the middle of an operation.
        @(negedge clk);
        drive(1'b1, KC1, CC1, 1'b1);
        @(negedge clk);
        drive(1'b1, '0, '0, 1'b0);
        n = 0;
        while (bus_f.round != 4'd5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reach_round5", 128'(bus_f.round), 128'(5));
        rst = 1'b1;
        #1;
        chk("mid_block", bus_f.m_aes_block, '0);
        chk("mid_round", 128'(bus_f.round), 128'(0));
        chk("mid_rkey", bus_f.round_key, '0);
        chk("mid_valid", 128'(bus_f.m_aes_valid), 128'(0));
        chk("mid_ready", 128'(bus_f.s_aes_ready), 128'(0));
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus_f.m_aes_valid) pulses++;
        end
        rst = 1'b0;
        #1;
        chk("mid_rel_ready", 128'(bus_f.s_aes_ready), 128'(1));
        repeat (30) begin
            @(negedge clk);
            if (bus_f.m_aes_valid) pulses++;
        end
        chk("mid_no_pulse", 128'(pulses), 128'(0));
        run_vec(1'b1, KC1, CC1, PC1, K0C1, 20, "after_rst");

        // Loopback against the reference forward cipher, both cores at once.
        for (int i = 0; i < 1000; i++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            encrypt(key, pt, ct, rk);
            @(negedge clk);
            drive(1'b1, rk, ct, 1'b1);
            drive(1'b0, rk, ct, 1'b1);
            @(negedge clk);
            drive(1'b1, '0, '0, 1'b0);
            drive(1'b0, '0, '0, 1'b0);
            df = 1'b0; ds = 1'b0; gf = '0; gs = '0; n = 0;
            while (!(df && ds) && n < 200) begin
                @(negedge clk);
                n++;
                if (bus_f.m_aes_valid) begin df = 1'b1; gf = bus_f.m_aes_block; end
                if (bus_s.m_aes_valid) begin ds = 1'b1; gs = bus_s.m_aes_block; end
            end
            chk("loop_done_f", 128'(df), 128'(1));
            chk("loop_done_s", 128'(ds), 128'(1));
            chk("loop_pt_f", gf, pt);
            chk("loop_pt_s", gs, pt);
            chk("loop_key_s", bus_s.round_key, key);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_dec.md
Name: aes_dec

Overview:
- AES-128 decipher block per FIPS 197 (inverse cipher); the counterpart of the team's AES-128 encipher block.
- Input is a ciphertext plus the decipher key. The decipher key is the last (round-10) round key that the encipher block produces on its round_key output.
- Round keys are derived on the fly by inverse key expansion; no key storage RAM.
- Iterative: one round per pass, with the same FAST_MODE area/speed trade-off as the encipher block.

Parameters:
- FAST_MODE, 1, 1 = four inverse S-box words per cycle (1-cycle SubBytes); 0 = one word per cycle (4-cycle SubBytes), less logic.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- s_aes_key  in  128  decipher key = round-10 key, sampled on accept
- s_aes_block  in  128  ciphertext, sampled on accept
- s_aes_valid  in  1  input valid
- s_aes_ready  out  1  high when idle and not in reset
- m_aes_block  out  128  working state; plaintext when m_aes_valid=1
- m_aes_valid  out  1  one-cycle pulse, plaintext valid
- round  out  4  current round-key index 10..0 (verification)
- round_key  out  128  current round key; equals cipher key after completion

Behaviour:
- Reset (async, any time including mid-operation):
  - all registers cleared: m_aes_block=0, m_aes_valid=0, round=0, round_key=0, rcon=0, FSM=IDLE.
  - s_aes_ready=0 while rst is high, 1 in the first cycle after rst releases.
  - any operation in progress is aborted; no m_aes_valid pulse is issued for it.
- Accept: on an edge with s_aes_valid && s_aes_ready:
  - block <= s_aes_block ^ s_aes_key; rkey <= s_aes_key; round <= 10; rcon <= 8'h36; FSM -> SUB.
  - s_aes_valid while busy is ignored; the source must hold it until ready.
- s_aes_ready = (FSM==IDLE) and !rst, combinational.
- FSM states: IDLE, SUB, ADD.
- SUB:
  - block <= InvSubBytes(InvShiftRows(block)).
  - FAST_MODE=1: one cycle.
  - FAST_MODE=0: four cycles, word counter 0..3, MSW first, then -> ADD.
  - In the first SUB cycle, rkey <= previous round key and round <= round-1.
- Inverse key step, from current words w0..w3 (w0 = MSW):
  - w3' = w3^w2; w2' = w2^w1; w1' = w1^w0.
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {rcon,24'h0}.
  - Uses the forward S-box.
  - rcon <= inv_xtime(rcon) = rcon[0] ? ((rcon^8'h1b)>>1)|8'h80 : rcon>>1.
  - Sequence: 36,1b,80,40,20,10,08,04,02,01.
- ADD:
  - round>0: block <= InvMixColumns(block ^ rkey), FSM -> SUB.
  - round==0: block <= block ^ rkey, m_aes_valid <= 1 for one cycle, FSM -> IDLE.
- Latency (accept edge = T0):
  - FAST_MODE=1: final block registered at T0+20, m_aes_valid high the cycle after T0+20.
  - FAST_MODE=0: same, at T0+50.
- Back-to-back: a new accept is possible in the same cycle m_aes_valid is high (ready is already 1).
- m_aes_block holds the plaintext until the next accept or reset.
- InvMixColumns per column uses coefficients {0e,0b,0d,09}, built from repeated xtime.

Decomposition:
- Shared package aes_pkg:
  - forward and inverse S-box constant tables;
  - functions xtime, inv_xtime, inv_shift_rows, inv_mix_columns;
  - Nk/Nr constants; the state-enum typedef.
- The encipher block migrates to the same package later.
- One sub-module, aes_inv_sbox_word: 32-bit combinational inverse S-box lookup, instantiated 4× (FAST_MODE=1) or 1× (FAST_MODE=0).
- Key-path SubWord reuses a forward-S-box word lookup from the package.

Test Plan:
- FIPS-197 C.1, key 13111d7fe3944a17f307a78b4d2b30c5, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> m_aes_block=00112233445566778899aabbccddeeff with m_aes_valid at T0+20 (FAST) and T0+50 (slow); round_key=000102030405060708090a0b0c0d0e0f.
- FIPS-197 App. B, key d014f9a8c9ee2589e13f0cc8b6630ca6, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734; round steps 10..0; rcon sequence exactly 36..01.
- s_aes_valid held high across two vectors -> s_aes_ready low while busy; second vector accepted in the m_aes_valid cycle; both results correct, with no idle gap.
- rst asserted at round 5 -> all outputs 0 immediately, no m_aes_valid pulse; after release, a new C.1 vector decrypts correctly.
- Loopback with the encipher block: 1000 random key/pt pairs, encipher round_key -> aes_dec key, encipher output -> aes_dec ct -> recovered pt == original for both FAST_MODE values.
